ifetch_ctrl: RTL and testbench
==============================

// Module: ifetch_ctrl
// PURPOSE
//  Fetch-stage sequencer for the instruction memory. Owns the PC, issues word reads
//  to a fixed-latency instruction memory, and buffers returned words with their PC.
//  Hands them to decode via a valid/ready handshake. Redirects on branch/jump
//  (flush + epoch discard of in-flight reads). Sits between instruction memory and
//  the IF/ID pipeline register.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; first fetch address.
//  MEM_LAT    1              imem read latency in cycles (legal 1..4).
//  BUF_DEPTH  4              fetch buffer entries (power of 2, >= MEM_LAT+1 for full rate).
// PORTS
//  clk             in   1   single clock; all state updates on posedge.
//  rst_n           in   1   asynchronous, active-low reset.
//  fetch_en        in   1   1 = allowed to issue new reads.
//  imem_req        out  1   read request this cycle.
//  imem_addr       out  32  byte address of request; bits [1:0] always 00.
//  imem_rdata      in   32  read data, valid exactly MEM_LAT cycles after imem_req.
//  redirect_valid  in   1   branch/jump taken; flush and refetch.
//  redirect_pc     in   32  new PC; bits [1:0] ignored and forced to 00.
//  if_valid        out  1   if_instr/if_pc hold a valid fetched word.
//  if_ready        in   1   decode accepts; transfer when if_valid & if_ready.
//  if_instr        out  32  instruction at buffer head.
//  if_pc           out  32  byte PC of if_instr.
//  fsm_state       out  2   debug: 00 IDLE, 01 FETCH, 10 WAIT.
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC, buffer empty, in-flight=0,
//   epoch=0, state=IDLE. Outputs: imem_req=0, imem_addr=RESET_PC, if_valid=0,
//   if_instr=0, if_pc=0, fsm_state=00.
//  credit = BUF_DEPTH - (occupancy + in_flight) + pop, where pop = if_valid & if_ready.
//  issue = fetch_en & ~redirect_valid & (credit > 0). imem_req = issue (combinational).
//   imem_addr = pc. On issue: pc <= pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
//  In-flight tracking: MEM_LAT-deep shift register of {valid, epoch, pc}.
//   A slot retiring with a matching epoch pushes {imem_rdata, pc} into the buffer.
//   A mismatching epoch drops the slot silently.
//  Latency: req in cycle N -> if_valid in cycle N+MEM_LAT+1 (buffer write at end of
//   N+MEM_LAT). Steady state gives 1 instr/cycle when BUF_DEPTH >= MEM_LAT+1.
//  if_valid = ~empty & ~redirect_valid. Head is stable while if_valid & ~if_ready.
//  Redirect cycle: no issue, no pop. At the edge: buffer cleared, epoch toggles,
//   pc <= {redirect_pc[31:2],2'b00}. In-flight slots retire as stale and are dropped.
//   The first new request goes out the next cycle (if fetch_en).
//  Simultaneous push and pop: both occur. Occupancy is unchanged and ordering is kept.
//   Overflow cannot occur by the credit rule; the bench asserts this.
//  Back-to-back redirects: each one re-flushes. Only the last redirect_pc is fetched.
//  fetch_en=0: issue stops. In-flight reads still complete into the buffer.
//   The buffer still drains.
//  FSM: IDLE --fetch_en--> FETCH. FETCH --credit==0 & ~redirect--> WAIT.
//   WAIT --credit>0--> FETCH. FETCH/WAIT --~fetch_en--> IDLE.
//   A redirect from any state returns to FETCH if fetch_en, else IDLE.
//  Reset mid-operation: all state returns to reset values immediately.
//   In-flight data arriving after reset release is discarded (valid slots cleared).
// TESTING
//  1 Reset release, fetch_en=1, if_ready=1, MEM_LAT=1 -> imem_addr 0,4,8,... each
//    cycle; if_valid from cycle 2; if_pc 0,4,8 with matching mem words.
//  2 if_ready=0 for 10 cycles -> exactly BUF_DEPTH=4 issues then imem_req=0,
//    fsm_state=WAIT, if_pc held at 0. Release -> pcs 0,4,8,12,16 in order, no gaps.
//  3 redirect_valid with redirect_pc=32'h0000_0043 while 2 reads are in flight
//    (MEM_LAT=2) -> if_valid=0 that cycle. Next request addr 32'h40. Stale words
//    are never presented. First if_pc=32'h40.
//  4 Redirect to 32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 4.
//  5 rst_n pulsed low mid-stream with buffer full -> if_valid=0 and
//    imem_addr=RESET_PC asynchronously. After release, refetch starts from RESET_PC.
//  6 fetch_en toggled 1,0,1 with random if_ready -> no lost/duplicated PCs, in-order
//    delivery, scoreboard match against the memory image.

Source files
------------

// File: rtl/ifetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues fixed-latency imem reads, tracks them
// in a shift register and buffers returned words with their PC for decode.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_LAT   = 1,
  parameter int          BUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic [1:0]  fsm_state_o
);
  localparam int AW = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_FETCH = 2'b01, S_WAIT = 2'b10} state_e;

  state_e                      state_q, state_d;
  logic [31:0]                 pc_q;
  logic                        epoch_q;
  logic [MEM_LAT-1:0]          slot_vld_q, slot_ep_q;
  logic [MEM_LAT-1:0][31:0]    slot_pc_q;
  logic [BUF_DEPTH-1:0][31:0]  buf_instr_q, buf_pc_q;
  logic [AW:0]                 wr_ptr_q, rd_ptr_q, occ;
  logic [31:0]                 in_flight, credit, redir_pc;
  logic                        issue, pop, push, empty;

  assign occ      = wr_ptr_q - rd_ptr_q;
  assign empty    = (occ == '0);
  assign redir_pc = redirect_pc_i & ~32'h3;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < MEM_LAT; i++) in_flight = in_flight + 32'(slot_vld_q[i]);
  end

  assign if_valid_o  = ~empty & ~redirect_valid_i;
  assign pop         = if_valid_o & if_ready_i;
  // Slots already in flight hold buffer space, so a retiring word always has room.
  assign credit      = 32'(BUF_DEPTH) - (32'(occ) + in_flight) + 32'(pop);
  assign issue       = fetch_en_i & ~redirect_valid_i & (credit != '0);
  assign push        = slot_vld_q[MEM_LAT-1] & (slot_ep_q[MEM_LAT-1] == epoch_q);
  assign imem_req_o  = issue;
  assign imem_addr_o = pc_q;
  assign if_instr_o  = buf_instr_q[rd_ptr_q[AW-1:0]];
  assign if_pc_o     = buf_pc_q[rd_ptr_q[AW-1:0]];
  assign fsm_state_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      epoch_q <= 1'b0;
    end else if (redirect_valid_i) begin
      pc_q    <= redir_pc;
      epoch_q <= ~epoch_q;
    end else if (issue) begin
      pc_q    <= pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld_q <= '0;
      slot_ep_q  <= '0;
      slot_pc_q  <= '0;
    end else begin
      slot_vld_q[0] <= issue;
      slot_ep_q[0]  <= epoch_q;
      slot_pc_q[0]  <= pc_q;
      for (int i = 1; i < MEM_LAT; i++) begin
        slot_vld_q[i] <= slot_vld_q[i-1];
        slot_ep_q[i]  <= slot_ep_q[i-1];
        slot_pc_q[i]  <= slot_pc_q[i-1];
      end
      // Killing slots as well as toggling the epoch keeps back-to-back
      // redirects from reviving reads issued two epochs ago.
      if (redirect_valid_i) slot_vld_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
    end else if (redirect_valid_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        buf_instr_q[wr_ptr_q[AW-1:0]] <= imem_rdata_i;
        buf_pc_q[wr_ptr_q[AW-1:0]]    <= slot_pc_q[MEM_LAT-1];
        wr_ptr_q                      <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid_i) begin
      state_d = fetch_en_i ? S_FETCH : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (fetch_en_i) state_d = S_FETCH;
        S_FETCH: if (!fetch_en_i) state_d = S_IDLE;
                 else if (credit == '0) state_d = S_WAIT;
        S_WAIT:  if (!fetch_en_i) state_d = S_IDLE;
                 else if (credit != '0) state_d = S_FETCH;
        default: state_d = S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: one instance at MEM_LAT=1 and one at MEM_LAT=2,
// each fed by its own fixed-latency memory model, sharing all control inputs.
module tb_ifetch_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        fetch_en = 1'b0, redirect_valid = 1'b0, if_ready = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic        a_req, a_valid, b_req, b_valid;
  logic [31:0] a_addr, a_rdata, a_instr, a_pc, b_addr, b_rdata, b_instr, b_pc;
  logic [1:0]  a_state, b_state;

  int errors = 0, checks = 0;
  int n_iss, n_xfer;
  logic        sb_on = 1'b0, ovf = 1'b0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  logic [31:0] a_q, b_q1, b_q2;
  always @(posedge clk) begin
    a_q  <= a_addr;
    b_q1 <= b_addr;
    b_q2 <= b_q1;
  end
  assign a_rdata = mem_word(a_q);
  assign b_rdata = mem_word(b_q2);

  ifetch_ctrl #(.RESET_PC(32'h0), .MEM_LAT(1), .BUF_DEPTH(4)) dA (
    .clk(clk), .rst_n(rst_n), .fetch_en_i(fetch_en), .imem_req_o(a_req),
    .imem_addr_o(a_addr), .imem_rdata_i(a_rdata), .redirect_valid_i(redirect_valid),
    .redirect_pc_i(redirect_pc), .if_valid_o(a_valid), .if_ready_i(if_ready),
    .if_instr_o(a_instr), .if_pc_o(a_pc), .fsm_state_o(a_state));

  ifetch_ctrl #(.RESET_PC(32'h0), .MEM_LAT(2), .BUF_DEPTH(4)) dB (
    .clk(clk), .rst_n(rst_n), .fetch_en_i(fetch_en), .imem_req_o(b_req),
    .imem_addr_o(b_addr), .imem_rdata_i(b_rdata), .redirect_valid_i(redirect_valid),
    .redirect_pc_i(redirect_pc), .if_valid_o(b_valid), .if_ready_i(if_ready),
    .if_instr_o(b_instr), .if_pc_o(b_pc), .fsm_state_o(b_state));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Leaves the bench at a negedge with reset just released: cycle 0 starts here.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; if_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (int'(dA.occ) > 4 || int'(dB.occ) > 4) ovf = 1'b1;
  end

  // In-order scoreboard on instance A, active only while sb_on.
  always @(negedge clk) begin
    #2;
    if (sb_on) begin
      if (a_req) n_iss++;
      if (a_valid && if_ready) begin
        chk("t6_pc", a_pc, exp_pc);
        chk("t6_instr", a_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_xfer++;
      end
    end
  end

  initial begin
    int nreq;
    // Reset state
    #1;
    chk("rst_req", 32'(a_req), 0);
    chk("rst_addr", a_addr, 32'h0);
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_instr", a_instr, 0);
    chk("rst_pc", a_pc, 0);
    chk("rst_state", 32'(a_state), 0);

    // 1: full-rate streaming at MEM_LAT=1
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk($sformatf("t1_req%0d", c), 32'(a_req), 1);
      chk($sformatf("t1_addr%0d", c), a_addr, 32'(4 * c));
      if (c >= 2) begin
        chk($sformatf("t1_valid%0d", c), 32'(a_valid), 1);
        chk($sformatf("t1_pc%0d", c), a_pc, 32'(4 * (c - 2)));
        chk($sformatf("t1_instr%0d", c), a_instr, mem_word(32'(4 * (c - 2))));
      end else begin
        chk($sformatf("t1_valid%0d", c), 32'(a_valid), 0);
      end
    end

    // 2: backpressure fills the buffer, then drains in order
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b0; nreq = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      nreq += int'(a_req);
    end
    chk("t2_nreq", 32'(nreq), 4);
    chk("t2_state", 32'(a_state), 2);
    chk("t2_req", 32'(a_req), 0);
    chk("t2_hold_pc", a_pc, 0);
    @(negedge clk);
    if_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("t2_valid%0d", k), 32'(a_valid), 1);
      chk($sformatf("t2_pc%0d", k), a_pc, 32'(4 * k));
    end

    // 3: redirect with two reads in flight at MEM_LAT=2
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    #1 chk("t3_addr2", b_addr, 32'h8);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
    #1;
    chk("t3_valid_redir", 32'(b_valid), 0);
    chk("t3_req_redir", 32'(b_req), 0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("t3_req4", 32'(b_req), 1);
    chk("t3_addr4", b_addr, 32'h40);
    chk("t3_valid4", 32'(b_valid), 0);
    @(negedge clk); #1 chk("t3_valid5", 32'(b_valid), 0);
    @(negedge clk); #1 chk("t3_valid6", 32'(b_valid), 0);
    @(negedge clk); #1;
    chk("t3_valid7", 32'(b_valid), 1);
    chk("t3_pc7", b_pc, 32'h40);
    chk("t3_instr7", b_instr, mem_word(32'h40));
    @(negedge clk); #1 chk("t3_pc8", b_pc, 32'h44);

    // 4: back-to-back redirects, last one wraps past the top of memory
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b1;
    #1 chk("t4_addr0", a_addr, 32'h0);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    #1 chk("t4_req1", 32'(a_req), 0);
    @(negedge clk);
    redirect_pc = 32'hFFFF_FFF8;
    #1;
    chk("t4_req2", 32'(a_req), 0);
    chk("t4_valid2", 32'(a_valid), 0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("t4_req3", 32'(a_req), 1);
    chk("t4_addr3", a_addr, 32'hFFFF_FFF8);
    @(negedge clk); #1;
    chk("t4_addr4", a_addr, 32'hFFFF_FFFC);
    chk("t4_valid4", 32'(a_valid), 0);
    @(negedge clk); #1;
    chk("t4_addr5", a_addr, 32'h0);
    chk("t4_pc5", a_pc, 32'hFFFF_FFF8);
    @(negedge clk); #1;
    chk("t4_addr6", a_addr, 32'h4);
    chk("t4_pc6", a_pc, 32'hFFFF_FFFC);
    @(negedge clk); #1 chk("t4_pc7", a_pc, 32'h0);

    // 5: async reset with a full buffer
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b0;
    repeat (8) @(negedge clk);
    #1 chk("t5_full_valid", 32'(a_valid), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(a_valid), 0);
    chk("t5_rst_addr", a_addr, 32'h0);
    chk("t5_rst_state", 32'(a_state), 0);
    @(negedge clk);
    rst_n = 1'b1; if_ready = 1'b1;
    #1;
    chk("t5_req0", 32'(a_req), 1);
    chk("t5_addr0", a_addr, 32'h0);
    @(negedge clk); @(negedge clk); #1;
    chk("t5_valid2", 32'(a_valid), 1);
    chk("t5_pc2", a_pc, 32'h0);
    chk("t5_instr2", a_instr, mem_word(32'h0));

    // 6: fetch_en toggling with random backpressure, scoreboarded
    do_reset();
    exp_pc = '0; n_iss = 0; n_xfer = 0; sb_on = 1'b1;
    for (int c = 0; c < 90; c++) begin
      if (c > 0) @(negedge clk);
      fetch_en = (c < 30) || (c >= 50 && c < 75);
      if_ready = 1'($urandom_range(0, 1));
      if (c == 40) begin
        #1;
        chk("t6_idle_state", 32'(a_state), 0);
        chk("t6_idle_req", 32'(a_req), 0);
      end
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      fetch_en = 1'b0; if_ready = 1'b1;
    end
    @(negedge clk);
    sb_on = 1'b0;
    chk("t6_issued", 32'(n_iss > 0), 1);
    chk("t6_count", 32'(n_xfer), 32'(n_iss));
    chk("no_overflow", 32'(ovf), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
